// File: rtl/adc_word_packer.sv
// Packs enabled ADC channel samples LSB-first into OUT_W-bit FIFO words.
// Capture start/stop with end-of-capture flush, full-drop overflow flag and a word counter.
module adc_word_packer #(
    parameter int SAMPLE_W = 8,
    parameter int NCH      = 2,
    parameter int OUT_W    = 32,
    parameter int CNT_W    = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    capture_en,
    input  logic [NCH-1:0]          ch_en,
    input  logic                    sample_valid,
    input  logic [NCH*SAMPLE_W-1:0] samples,
    input  logic                    fifo_full,
    input  logic                    ovf_clr,
    output logic                    wr_en,
    output logic [OUT_W-1:0]        wr_data,
    output logic                    overflow,
    output logic [CNT_W-1:0]        word_count,
    output logic                    busy
);
    localparam int LANES  = OUT_W / SAMPLE_W;
    localparam int TOT    = LANES + NCH;
    localparam int ACC_W  = TOT * SAMPLE_W;
    localparam int FILL_W = $clog2(TOT + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;

    logic [1:0]        state_q, state_d;
    logic              cap_q;
    logic [NCH-1:0]    mask_q, mask_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic              wr_en_q, wr_en_d;
    logic [OUT_W-1:0]  wr_data_q, wr_data_d;
    logic              ovf_q, ovf_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [ACC_W-1:0]  acc_ext;
    logic [OUT_W-1:0]  word;
    logic              word_vld;
    int                pos;

    always_comb begin
        state_d   = state_q;
        mask_d    = mask_q;
        fill_d    = fill_q;
        acc_d     = acc_q;
        wr_en_d   = 1'b0;
        wr_data_d = wr_data_q;
        ovf_d     = ovf_q;
        cnt_d     = cnt_q;
        acc_ext   = acc_q;
        pos       = int'(fill_q);
        word      = acc_q[OUT_W-1:0];
        word_vld  = 1'b0;

        if (ovf_clr) ovf_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (capture_en && !cap_q) begin
                    mask_d  = ch_en;
                    fill_d  = '0;
                    acc_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (!capture_en) begin
                    state_d = S_FLUSH;
                end else if (sample_valid) begin
                    // Enabled channels land in consecutive slots starting at fill
                    for (int c = 0; c < NCH; c++) begin
                        if (mask_q[c]) begin
                            acc_ext[pos*SAMPLE_W +: SAMPLE_W] = samples[c*SAMPLE_W +: SAMPLE_W];
                            pos = pos + 1;
                        end
                    end
                    if (pos >= LANES) begin
                        word_vld = 1'b1;
                        word     = acc_ext[OUT_W-1:0];
                        acc_d    = acc_ext >> OUT_W;
                        fill_d   = FILL_W'(pos - LANES);
                    end else begin
                        acc_d  = acc_ext;
                        fill_d = FILL_W'(pos);
                    end
                end
            end
            S_FLUSH: begin
                // Slots above fill are always zero, so the low OUT_W bits are already padded
                if (fill_q != '0) begin
                    word_vld = 1'b1;
                    word     = acc_q[OUT_W-1:0];
                end
                fill_d  = '0;
                acc_d   = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (word_vld) begin
            if (fifo_full) begin
                ovf_d = 1'b1;
            end else begin
                wr_en_d   = 1'b1;
                wr_data_d = word;
                cnt_d     = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cap_q     <= 1'b0;
            mask_q    <= '0;
            fill_q    <= '0;
            acc_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_data_q <= '0;
            ovf_q     <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            cap_q     <= capture_en;
            mask_q    <= mask_d;
            fill_q    <= fill_d;
            acc_q     <= acc_d;
            wr_en_q   <= wr_en_d;
            wr_data_q <= wr_data_d;
            ovf_q     <= ovf_d;
            cnt_q     <= cnt_d;
        end
    end

    assign wr_en      = wr_en_q;
    assign wr_data    = wr_data_q;
    assign overflow   = ovf_q;
    assign word_count = cnt_q;
    assign busy       = (state_q == S_RUN) || (state_q == S_FLUSH);

endmodule
